// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch front end. Sequential fetch with at most one request
//   outstanding to instruction memory, a small circular queue of fetched
//   words, redirect (branch/jump) flush with in-flight response discard,
//   and a halt opcode that stops fetching until the next redirect.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_req, mem_addr        read request to instruction memory (held until ack)
//   mem_ack, mem_rdata       response strobe and data (rdata valid only with ack)
//   inst_valid, inst,
//   inst_pc, inst_ready      queue head handshake towards the decoder
//   redirect, redirect_pc    flush queue and restart fetch at redirect_pc
//   pc                       next address to be requested
//   hlt                      halted and queue drained
module fetch_queue_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        INST_W   = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        PC_INC   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [3:0]         HLT_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              hlt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic req_raw;
    logic enq;
    logic deq;
    logic flush;
    logic is_halt_word;

    assign inst_valid   = (count_q != '0);
    assign deq          = inst_valid & inst_ready;
    assign is_halt_word = (mem_rdata[INST_W-1 -: 4] == HLT_OP);

    // ------------------------------------------------------------------
    // Fetch FSM: next state, request outputs, enqueue/flush strobes
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_raw    = 1'b0;
        mem_addr   = req_addr_q;
        enq        = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_addr = pc_q;
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else if (count_q < FULL_CNT) begin
                    // Only issue when the response is guaranteed a queue slot.
                    req_raw    = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = mem_ack ? FETCH : DISCARD;
                end else if (mem_ack) begin
                    enq = 1'b1;
                    if (is_halt_word) begin
                        // pc stays on the halt word.
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(PC_INC);
                        state_d = FETCH;
                    end
                end
            end
            DISCARD: begin
                // Stale request stays on the bus until memory answers it.
                req_raw = 1'b1;
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                mem_addr = pc_q;
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // The reset state is FETCH with an empty queue, which would otherwise
    // present a request while rst_n is still low.
    assign mem_req = rst_n & req_raw;

    // ------------------------------------------------------------------
    // Queue pointer/occupancy next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign inst = inst_mem_q[rd_ptr_q];
    assign inst_pc = pc_mem_q[rd_ptr_q];
    assign pc = pc_q;
    assign hlt = (state_q == HALT) && (count_q == '0);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed scenarios driving a latency-
// programmable memory responder, a queue-based reference model compared
// against the DUT every cycle, and literal expectations at key points.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'hF0F0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] pc;
    logic        hlt;

    int checks = 0;
    int failures = 0;

    fetch_queue_unit #(
        .ADDR_W(16), .INST_W(16), .DEPTH(DEPTH), .PC_INC(2),
        .RESET_PC(16'h0000), .HLT_OP(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .hlt(hlt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [15:0] halt_addr = 16'hFFFF;
    logic [15:0] dead_addr = 16'hFFFD;
    int          mem_lat = 1;
    bit          pend = 1'b0;
    bit          ack_prev = 1'b0;
    int          cnt = 0;
    logic [15:0] pend_addr = 16'h0000;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        if (a == halt_addr) return 16'hF000;
        if (a == dead_addr) return 16'hDEAD;
        return 16'h1000 + (a >> 1);
    endfunction

    // One clock: sample the request just before the edge, then update the
    // memory's response shortly after it.
    task automatic tick();
        bit          req_seen;
        logic [15:0] addr_seen;
        @(negedge clk);
        req_seen  = mem_req;
        addr_seen = mem_addr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend = 1'b0; ack_prev = 1'b0; mem_ack = 1'b0; mem_rdata = 16'hF0F0;
            return;
        end
        if (ack_prev) pend = 1'b0;
        else if (pend) cnt--;
        else if (req_seen) begin
            pend = 1'b1; cnt = mem_lat; pend_addr = addr_seen;
        end
        ack_prev  = pend && (cnt == 1);
        mem_ack   = ack_prev;
        mem_rdata = ack_prev ? word_at(pend_addr) : 16'hF0F0;
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct packed {
        logic [15:0] w;
        logic [15:0] a;
    } ent_t;

    ent_t        mq[$];
    ent_t        deq_log[$];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_req_addr = 16'h0000;
    bit          m_out = 1'b0;
    bit          m_disc = 1'b0;
    bit          m_halt = 1'b0;
    int          dead_seen = 0;

    always @(negedge clk) begin
        bit exp_req;
        bit exp_deq;
        if (!rst_n) begin
            check("rst_mem_req", 32'(mem_req), 32'h0);
            check("rst_inst_valid", 32'(inst_valid), 32'h0);
            check("rst_hlt", 32'(hlt), 32'h0);
            check("rst_pc", 32'(pc), 32'h0000);
            mq.delete();
            m_pc = 16'h0000; m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0;
        end else begin
            exp_req = m_out || (!m_halt && !redirect && mq.size() < DEPTH);
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req && mem_req)
                check("mem_addr", 32'(mem_addr), 32'(m_out ? m_req_addr : m_pc));
            check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("inst", 32'(inst), 32'(mq[0].w));
                check("inst_pc", 32'(inst_pc), 32'(mq[0].a));
            end
            check("pc", 32'(pc), 32'(m_pc));
            check("hlt", 32'(hlt), 32'(m_halt && mq.size() == 0));

            if (inst_valid && inst_ready) begin
                deq_log.push_back('{w: inst, a: inst_pc});
                if (inst == 16'hDEAD) dead_seen++;
            end

            exp_deq = (mq.size() != 0) && inst_ready;
            if (exp_deq) void'(mq.pop_front());

            if (redirect) begin
                mq.delete();
                m_pc   = redirect_pc;
                m_halt = 1'b0;
                if (m_out && !mem_ack) m_disc = 1'b1;
                else begin m_out = 1'b0; m_disc = 1'b0; end
            end else if (m_out && mem_ack) begin
                m_out = 1'b0;
                if (!m_disc) begin
                    mq.push_back('{w: mem_rdata, a: m_req_addr});
                    if (mem_rdata[15:12] == 4'hF) m_halt = 1'b1;
                    else m_pc = m_pc + 16'd2;
                end
                m_disc = 1'b0;
            end else if (exp_req && !m_out) begin
                m_out      = 1'b1;
                m_req_addr = m_pc;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'hF0F0;
        tick();
        tick();
        rst_n = 1'b1;
        deq_log.delete();
    endtask

    task automatic check_log(input int idx, input logic [15:0] w, input logic [15:0] a);
        if (deq_log.size() > idx) begin
            check($sformatf("log%0d_word", idx), 32'(deq_log[idx].w), 32'(w));
            check($sformatf("log%0d_pc", idx), 32'(deq_log[idx].a), 32'(a));
        end else begin
            check($sformatf("log%0d_len", idx), 32'(deq_log.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Sequential fetch, latency 1, consumer always ready.
        mem_lat = 1; inst_ready = 1'b1;
        do_reset();
        #1;
        check("first_req", 32'(mem_req), 32'h1);
        check("first_addr", 32'(mem_addr), 32'h0000);
        repeat (10) tick();
        check_log(0, 16'h1000, 16'h0000);
        check_log(1, 16'h1001, 16'h0002);
        check_log(2, 16'h1002, 16'h0004);
        check_log(3, 16'h1003, 16'h0006);

        // Backpressure: queue fills to DEPTH, fetch stops at 0x0008.
        mem_lat = 1; inst_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        check("bp_mem_req", 32'(mem_req), 32'h0);
        check("bp_pc", 32'(pc), 32'h0008);
        check("bp_head_pc", 32'(inst_pc), 32'h0000);
        check("bp_no_deq", 32'(deq_log.size()), 32'h0);
        inst_ready = 1'b1;
        tick();
        check("bp_resume_req", 32'(mem_req), 32'h1);
        check("bp_resume_addr", 32'(mem_addr), 32'h0008);
        repeat (12) tick();
        check_log(4, 16'h1004, 16'h0008);

        // Redirect while waiting, second redirect in DISCARD, stale 0xDEAD.
        mem_lat = 3; inst_ready = 1'b1; dead_addr = 16'h0000;
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0030;
        tick();
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        tick();
        check("disc_next_req", 32'(mem_req), 32'h1);
        check("disc_next_addr", 32'(mem_addr), 32'h0040);
        check("disc_pc", 32'(pc), 32'h0040);
        repeat (10) tick();
        check("dead_never_seen", 32'(dead_seen), 32'h0);
        check_log(0, 16'h1020, 16'h0040);
        dead_addr = 16'hFFFD;

        // Redirect coincident with ack and with a dequeue.
        mem_lat = 1; inst_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 16'h0100; inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        check("rack_empty", 32'(inst_valid), 32'h0);
        check("rack_pc", 32'(pc), 32'h0100);
        check("rack_req", 32'(mem_req), 32'h1);
        check("rack_addr", 32'(mem_addr), 32'h0100);
        check("rack_deq_count", 32'(deq_log.size()), 32'h1);
        repeat (4) tick();
        check_log(1, 16'h1080, 16'h0100);

        // Halt word at 0x000A, then redirect to 0 restarts fetch.
        mem_lat = 1; inst_ready = 1'b1; halt_addr = 16'h000A;
        do_reset();
        repeat (16) tick();
        check("halt_hlt", 32'(hlt), 32'h1);
        check("halt_no_req", 32'(mem_req), 32'h0);
        check("halt_pc", 32'(pc), 32'h000A);
        check_log(5, 16'hF000, 16'h000A);
        halt_addr = 16'hFFFF;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        #1;
        check("restart_hlt", 32'(hlt), 32'h0);
        check("restart_req", 32'(mem_req), 32'h1);
        check("restart_addr", 32'(mem_addr), 32'h0000);

        // Address wrap at 0xFFFE plus queue pointer wrap under backpressure.
        mem_lat = 1; inst_ready = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFF8;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 40; i++) begin
            inst_ready = (i % 3) != 2;
            tick();
        end
        check_log(0, 16'h8FFC, 16'hFFF8);
        check_log(3, 16'h8FFF, 16'hFFFE);
        check_log(4, 16'h1000, 16'h0000);
        check_log(9, 16'h1005, 16'h000A);

        // Asynchronous reset in the middle of activity.
        mem_lat = 3; inst_ready = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'h0);
        check("async_rst_valid", 32'(inst_valid), 32'h0);
        check("async_rst_pc", 32'(pc), 32'h0000);
        mem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        deq_log.delete();
        #1;
        check("post_rst_req", 32'(mem_req), 32'h1);
        check("post_rst_addr", 32'(mem_addr), 32'h0000);
        repeat (10) tick();
        check_log(0, 16'h1000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
